// File: rtl/pixel_color_counter.sv
// Classifies RGB332 pixels as red, blue or neither and publishes per-frame counts
// at each rising VGA_VSYNC_NEG edge; single clock domain.
module pixel_color_counter #(
  parameter int         SCREEN_WIDTH  = 176,
  parameter int         SCREEN_HEIGHT = 144,
  parameter int         COUNT_W       = 10,
  parameter logic [2:0] RED_MIN       = 3'd5,
  parameter logic [1:0] BLUE_MIN      = 2'd2,
  parameter logic [2:0] OTHER_MAX     = 3'd2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         PIXEL_IN,
  input  logic               PIXEL_VALID,
  input  logic               VGA_VSYNC_NEG,
  output logic [COUNT_W-1:0] REDCOUNT,
  output logic [COUNT_W-1:0] BLUECOUNT,
  output logic               FRAME_DONE,
  output logic               FRAME_ERR
);

  localparam int                 TOT_W     = 15;
  localparam logic [TOT_W-1:0]   FRAME_PIX = TOT_W'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [TOT_W-1:0]   TOT_MAX   = '1;
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    SYNC,
    BLANK,
    ACTIVE
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q;
  logic [COUNT_W-1:0] red_acc, blue_acc;
  logic [TOT_W-1:0]   pix_tot;

  logic [2:0] r_chan;
  logic [1:0] b_chan;
  logic [2:0] b3_chan;
  logic       is_red, is_blue;
  logic       vsync_rise;
  logic       count_en, publish;

  // Blue is widened to 3 bits by replicating its MSB so both channels compare on one scale.
  assign r_chan     = PIXEL_IN[7:5];
  assign b_chan     = PIXEL_IN[1:0];
  assign b3_chan    = {b_chan, b_chan[1]};
  assign is_red     = (r_chan >= RED_MIN) && (b3_chan <= OTHER_MAX);
  assign is_blue    = (b_chan >= BLUE_MIN) && (r_chan <= OTHER_MAX);
  assign vsync_rise = VGA_VSYNC_NEG && !vsync_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and infers a latch.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    publish  = 1'b0;
    unique case (state_q)
      SYNC:   if (VGA_VSYNC_NEG) state_d = BLANK;
      BLANK:  if (!VGA_VSYNC_NEG) state_d = ACTIVE;
      ACTIVE: begin
        if (vsync_rise) begin
          publish = 1'b1;
          state_d = BLANK;
        end else if (PIXEL_VALID && !VGA_VSYNC_NEG) begin
          count_en = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= SYNC;
      vsync_q    <= 1'b1;
      red_acc    <= '0;
      blue_acc   <= '0;
      pix_tot    <= '0;
      REDCOUNT   <= '0;
      BLUECOUNT  <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= VGA_VSYNC_NEG;
      FRAME_DONE <= publish;
      if (publish) begin
        REDCOUNT  <= red_acc;
        BLUECOUNT <= blue_acc;
        FRAME_ERR <= (pix_tot != FRAME_PIX);
        red_acc   <= '0;
        blue_acc  <= '0;
        pix_tot   <= '0;
      end else if (count_en) begin
        // All accumulators saturate rather than wrap.
        if (is_red && red_acc != CNT_MAX)   red_acc  <= red_acc + 1'b1;
        if (is_blue && blue_acc != CNT_MAX) blue_acc <= blue_acc + 1'b1;
        if (pix_tot != TOT_MAX)             pix_tot  <= pix_tot + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_color_counter.sv
// Directed self-checking bench for pixel_color_counter: frame counts, saturation,
// pixel-total error flag, classification boundaries and asynchronous reset.
module tb_pixel_color_counter;

  localparam int FRAME_PIX = 176 * 144;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PIXEL_IN;
  logic       PIXEL_VALID;
  logic       VGA_VSYNC_NEG;
  logic [9:0] REDCOUNT, BLUECOUNT;
  logic       FRAME_DONE, FRAME_ERR;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int done_ref;

  pixel_color_counter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PIXEL_IN     (PIXEL_IN),
    .PIXEL_VALID  (PIXEL_VALID),
    .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
    .REDCOUNT     (REDCOUNT),
    .BLUECOUNT    (BLUECOUNT),
    .FRAME_DONE   (FRAME_DONE),
    .FRAME_ERR    (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_DONE === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] px, input int n, input logic valid);
    for (int i = 0; i < n; i++) begin
      PIXEL_IN    = px;
      PIXEL_VALID = valid;
      tick();
    end
    PIXEL_VALID = 1'b0;
  endtask

  task automatic start_frame();
    VGA_VSYNC_NEG = 1'b0;
    PIXEL_VALID   = 1'b0;
    tick();
  endtask

  // Raises VSYNC; an optional red pixel is presented valid in the edge cycle.
  task automatic end_frame(input logic edge_valid);
    VGA_VSYNC_NEG = 1'b1;
    PIXEL_IN      = 8'hE0;
    PIXEL_VALID   = edge_valid;
    tick();
    PIXEL_VALID   = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int red, input int blue, input logic err);
    check({tag, ".done"}, 32'(FRAME_DONE), 32'd1);
    check({tag, ".red"},  32'(REDCOUNT),   32'(red));
    check({tag, ".blue"}, 32'(BLUECOUNT),  32'(blue));
    check({tag, ".err"},  32'(FRAME_ERR),  32'(err));
    tick();
    check({tag, ".done_low"}, 32'(FRAME_DONE), 32'd0);
    check({tag, ".red_hold"}, 32'(REDCOUNT),   32'(red));
    tick();
  endtask

  initial begin
    RESET         = 1'b1;
    PIXEL_IN      = 8'h00;
    PIXEL_VALID   = 1'b0;
    VGA_VSYNC_NEG = 1'b0;
    tick();
    tick();
    check("rst.red",  32'(REDCOUNT),   32'd0);
    check("rst.blue", 32'(BLUECOUNT),  32'd0);
    check("rst.done", 32'(FRAME_DONE), 32'd0);
    check("rst.err",  32'(FRAME_ERR),  32'd0);
    RESET = 1'b0;

    // 1: partial first frame after reset is dropped
    send(8'hE0, 500, 1'b1);
    VGA_VSYNC_NEG = 1'b1;
    repeat (5) tick();
    check("t1.no_done", 32'(done_cnt), 32'd0);
    check("t1.red",     32'(REDCOUNT), 32'd0);

    // 2: full frame of mixed pixels
    start_frame();
    send(8'hE0, 300, 1'b1);
    send(8'h03, 200, 1'b1);
    send(8'h1C, FRAME_PIX - 500, 1'b1);
    end_frame(1'b0);
    check_frame("t2", 300, 200, 1'b0);
    check("t2.one_pulse", 32'(done_cnt), 32'd1);

    // 3: all-red frame saturates the red count
    start_frame();
    send(8'hE0, FRAME_PIX, 1'b1);
    end_frame(1'b0);
    check_frame("t3", 1023, 0, 1'b0);

    // 4: short frame with gaps and a valid pixel on the edge cycle
    start_frame();
    send(8'hE0, 20, 1'b1);
    send(8'hE0, 10, 1'b0);
    send(8'hE0, 20, 1'b1);
    send(8'h03, 30, 1'b1);
    send(8'h1C, 30, 1'b1);
    end_frame(1'b1);
    check_frame("t4a", 40, 30, 1'b1);
    start_frame();
    send(8'hE0, 5, 1'b1);
    end_frame(1'b1);
    check_frame("t4b", 5, 0, 1'b1);

    // 5: classification boundaries (A0, A1 red; 42 blue; 83, A2, 62 neither)
    start_frame();
    send(8'hA0, 3, 1'b1);
    send(8'h83, 5, 1'b1);
    send(8'h42, 7, 1'b1);
    send(8'hA2, 11, 1'b1);
    send(8'hA1, 2, 1'b1);
    send(8'h62, 4, 1'b1);
    end_frame(1'b0);
    check_frame("t5", 5, 7, 1'b1);

    // 6: asynchronous reset mid-frame clears outputs at once and drops the frame
    start_frame();
    send(8'hE0, 50, 1'b1);
    RESET = 1'b1;
    #1;
    check("t6.red",  32'(REDCOUNT),   32'd0);
    check("t6.blue", 32'(BLUECOUNT),  32'd0);
    check("t6.done", 32'(FRAME_DONE), 32'd0);
    check("t6.err",  32'(FRAME_ERR),  32'd0);
    tick();
    RESET    = 1'b0;
    done_ref = done_cnt;
    send(8'h03, 50, 1'b1);
    VGA_VSYNC_NEG = 1'b1;
    repeat (5) tick();
    check("t6.dropped", 32'(done_cnt),  32'(done_ref));
    check("t6.blue0",   32'(BLUECOUNT), 32'd0);
    start_frame();
    send(8'h03, 9, 1'b1);
    end_frame(1'b0);
    check_frame("t6.next", 0, 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
